hazard_forward_ctrl: RTL
========================

Name: hazard_forward_ctrl

Overview:
Parametrised hazard and forwarding controller for the 5-stage pipelined CPU; replaces the purely combinational forwarding logic. It generates forwarding selects for the ID-stage branch comparator and the EXE ALU operands, with MEM priority over WB. It also detects load-use and branch-dependency stalls. A multi-cycle multiply/divide unit (MDU) busy FSM and a saturating stall-cycle counter provide the sequential state.

Parameters:
RA_W, 5, register address width
MDU_LAT, 4, cycles the MDU stays busy after an accepted start (legal range 1..15)
CNT_W, 32, stall counter width

Ports:
CLK  in  1  rising-edge clock
Reset  in  1  synchronous, active-high
ID_rs, ID_rt  in  RA_W  source registers of instruction in ID
ID_use_rs, ID_use_rt  in  1  ID instruction actually reads rs / rt
ID_is_branch  in  1  ID instruction compares registers in ID (beq/bne/jr)
ID_mdu_start  in  1  ID instruction starts an MDU op (mult/div)
ID_reads_hilo  in  1  ID instruction reads HI/LO (mfhi/mflo)
EXE_rs, EXE_rt  in  RA_W  source registers in EXE
EXE_writeSrc  in  RA_W  destination register in EXE
EXE_RegWrite, EXE_MemRead  in  1  EXE write enable / load flag
MEM_writeSrc  in  RA_W  destination register in MEM
MEM_RegWrite, MEM_MemRead  in  1  MEM write enable / load flag
WB_writeSrc  in  RA_W  destination register in WB
WB_RegWrite  in  1  WB write enable
forward_ID_A, forward_ID_B  out  2  ID comparator operand select
forward_EXE_A, forward_EXE_B  out  2  EXE ALU operand select
stall  out  1  hold PC and IF/ID register
bubble  out  1  load NOP into ID/EXE register
mdu_busy  out  1  MDU operation in flight
stall_count  out  CNT_W  total stall cycles since reset

Behaviour:
- Select encoding: 00 register file, 01 MEM result, 10 WB result. 11 is never driven.
- Match terms: match_X(r) = X_RegWrite & (X_writeSrc != 0) & (X_writeSrc == r).
- forward_EXE_A: 01 if match_MEM(EXE_rs); else 10 if match_WB(EXE_rs); else 00. forward_EXE_B is the same using EXE_rt.
- forward_ID_A: used only when ID_is_branch=1, otherwise 00. Value is 01 if match_MEM(ID_rs) & ~MEM_MemRead; else 10 if match_WB(ID_rs); else 00. forward_ID_B is the same using ID_rt.
- Stall sources, combinational:
  - load-use: EXE_MemRead & match_EXE(rs & use_rs | rt & use_rt);
  - branch-on-ALU: ID_is_branch & match_EXE(used src);
  - branch-on-load: ID_is_branch & MEM_MemRead & match_MEM(used src);
  - MDU: mdu_busy & (ID_mdu_start | ID_reads_hilo).
- stall = OR of all stall sources. bubble = stall.
- While Reset=1, stall and bubble are forced to 0.
- MDU FSM has states IDLE and BUSY, with a counter cnt of width clog2(MDU_LAT+1).
  - IDLE: if ID_mdu_start & ~stall, go to BUSY with cnt=MDU_LAT.
  - BUSY: cnt decrements each cycle. When cnt==1, return to IDLE next edge.
  - mdu_busy=1 exactly in BUSY, so it is high for MDU_LAT cycles starting the cycle after acceptance.
  - A start while BUSY is stalled, never accepted; no overlap.
- stall_count increments by 1 on every edge where stall=1, and saturates at all-ones (no wrap).
- Reset, including mid-operation: the FSM goes to IDLE, cnt=0, mdu_busy=0, stall_count=0, all effective on the next edge.
- Select outputs are purely combinational and are not gated by Reset.
- Latency: forwards and stall have zero cycle latency (combinational). mdu_busy and stall_count are registered.
- Register $0 never forwards and never stalls.

Test Plan:
1. EXE_rs=3; MEM_writeSrc=3, MEM_RegWrite=1; WB_writeSrc=3, WB_RegWrite=1 -> forward_EXE_A=01 (MEM priority). Drop MEM_RegWrite -> 10.
2. Load-use: EXE_MemRead=1, EXE_writeSrc=5, EXE_RegWrite=1, ID_rt=5, ID_use_rt=1 -> stall=bubble=1 for one cycle, stall_count 0->1. With ID_use_rt=0 -> stall=0.
3. Branch chain: ID_is_branch=1, ID_rs=7. EXE writes 7 (ALU) -> stall. Next cycle MEM writes 7 (ALU) -> no stall, forward_ID_A=01. Repeat with MEM_MemRead=1 -> stall one more cycle, then forward_ID_A=10.
4. MDU, MDU_LAT=4: accept ID_mdu_start at cycle t -> mdu_busy high cycles t+1..t+4. ID_reads_hilo at t+2 -> stall for cycles t+2..t+4, released at t+5; stall_count +=3.
5. Reset asserted at t+2 during MDU busy -> mdu_busy=0 and stall_count=0 after the edge. stall=0 while Reset is high.
6. Writes to $0 in MEM/WB/EXE with matching sources -> all selects 00, stall=0. Preload stall_count near all-ones (CNT_W=4, hold stall for 20 cycles) -> value holds at 15.

Source files
------------

// File: rtl/hazard_forward_ctrl.sv
// Hazard and forwarding controller for the 5-stage pipeline: branch/ALU forwarding selects,
// load-use and branch stalls, an MDU busy tracker and a saturating stall-cycle counter.
module hazard_forward_ctrl #(
  parameter int RA_W    = 5,
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [RA_W-1:0]  ID_rs,
  input  logic [RA_W-1:0]  ID_rt,
  input  logic             ID_use_rs,
  input  logic             ID_use_rt,
  input  logic             ID_is_branch,
  input  logic             ID_mdu_start,
  input  logic             ID_reads_hilo,
  input  logic [RA_W-1:0]  EXE_rs,
  input  logic [RA_W-1:0]  EXE_rt,
  input  logic [RA_W-1:0]  EXE_writeSrc,
  input  logic             EXE_RegWrite,
  input  logic             EXE_MemRead,
  input  logic [RA_W-1:0]  MEM_writeSrc,
  input  logic             MEM_RegWrite,
  input  logic             MEM_MemRead,
  input  logic [RA_W-1:0]  WB_writeSrc,
  input  logic             WB_RegWrite,
  output logic [1:0]       forward_ID_A,
  output logic [1:0]       forward_ID_B,
  output logic [1:0]       forward_EXE_A,
  output logic [1:0]       forward_EXE_B,
  output logic             stall,
  output logic             bubble,
  output logic             mdu_busy,
  output logic [CNT_W-1:0] stall_count
);

  // state   | meaning
  // IDLE    | no MDU operation in flight
  // BUSY    | MDU working, cnt_q = cycles left including this one
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam int MW = $clog2(MDU_LAT + 1);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;

  function automatic logic match(input logic we, input logic [RA_W-1:0] dst,
                                 input logic [RA_W-1:0] r);
    return we & (dst != '0) & (dst == r);
  endfunction

  function automatic logic [1:0] sel(input logic mem_hit, input logic wb_hit);
    return mem_hit ? SEL_MEM : (wb_hit ? SEL_WB : SEL_RF);
  endfunction

  logic [0:0]       state_q, state_d;
  logic [MW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  logic mem_a, mem_b, wb_a, wb_b;
  logic exe_id_a, exe_id_b, mem_id_a, mem_id_b;
  logic used_exe, used_mem;
  logic stall_raw;

  always_comb begin
    forward_EXE_A = sel(match(MEM_RegWrite, MEM_writeSrc, EXE_rs),
                        match(WB_RegWrite, WB_writeSrc, EXE_rs));
    forward_EXE_B = sel(match(MEM_RegWrite, MEM_writeSrc, EXE_rt),
                        match(WB_RegWrite, WB_writeSrc, EXE_rt));

    // A load result in MEM is not ready yet, so the branch stalls instead of forwarding it.
    mem_a = match(MEM_RegWrite, MEM_writeSrc, ID_rs) & ~MEM_MemRead;
    mem_b = match(MEM_RegWrite, MEM_writeSrc, ID_rt) & ~MEM_MemRead;
    wb_a  = match(WB_RegWrite, WB_writeSrc, ID_rs);
    wb_b  = match(WB_RegWrite, WB_writeSrc, ID_rt);
    forward_ID_A = ID_is_branch ? sel(mem_a, wb_a) : SEL_RF;
    forward_ID_B = ID_is_branch ? sel(mem_b, wb_b) : SEL_RF;

    exe_id_a = match(EXE_RegWrite, EXE_writeSrc, ID_rs) & ID_use_rs;
    exe_id_b = match(EXE_RegWrite, EXE_writeSrc, ID_rt) & ID_use_rt;
    mem_id_a = match(MEM_RegWrite, MEM_writeSrc, ID_rs) & ID_use_rs;
    mem_id_b = match(MEM_RegWrite, MEM_writeSrc, ID_rt) & ID_use_rt;
    used_exe = exe_id_a | exe_id_b;
    used_mem = mem_id_a | mem_id_b;

    stall_raw = (EXE_MemRead & used_exe)
              | (ID_is_branch & used_exe)
              | (ID_is_branch & MEM_MemRead & used_mem)
              | (mdu_busy & (ID_mdu_start | ID_reads_hilo));
    stall  = stall_raw & ~Reset;
    bubble = stall;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (ID_mdu_start && !stall) begin
          state_d = ST_BUSY;
          cnt_d   = MW'(MDU_LAT);
        end
      end
      default: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == MW'(1)) state_d = ST_IDLE;
      end
    endcase

    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != '1))
      stall_count_d = stall_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign mdu_busy    = (state_q == ST_BUSY);
  assign stall_count = stall_count_q;

endmodule
